// File: rtl/pipe_pkg.sv
// Shared types and constants for the RV32I pipeline-boundary registers.
package pipe_pkg;

  typedef struct packed {
    logic [1:0] wb_sel;
    logic       reg_wen;
    logic       pc_sel;
  } ctrl_t;

  localparam int CTRL_BITS = $bits(ctrl_t);

  // Safe control word: no register write-back, no PC redirect.
  localparam ctrl_t CTRL_NOP = '{wb_sel: 2'b00, reg_wen: 1'b0, pc_sel: 1'b0};

  typedef struct packed {
    logic [31:0] pc_plus4;
    logic [31:0] alu_result;
    logic [31:0] load_data;
    logic [31:0] instr;
  } mem_wb_data_t;

  localparam int MEM_WB_DATA_BITS = $bits(mem_wb_data_t);

endpackage

// File: rtl/pipe_slot.sv
// One pipeline entry: a valid bit plus payload register with load and clear.
// Clearing drops the valid bit only; the payload keeps its last value.
module pipe_slot
  import pipe_pkg::*;
#(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load_i,
  input  logic         clear_i,
  input  logic [W-1:0] d_i,
  output logic         valid_o,
  output logic [W-1:0] q_o
);

  logic         valid_q, valid_d;
  logic [W-1:0] data_q, data_d;

  always_comb begin
    valid_d = valid_q;
    data_d  = data_q;
    if (clear_i) begin
      valid_d = 1'b0;
    end else if (load_i) begin
      valid_d = 1'b1;
      data_d  = d_i;
    end else begin
      valid_d = valid_q;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_q <= 1'b0;
      data_q  <= '0;
    end else begin
      valid_q <= valid_d;
      data_q  <= data_d;
    end
  end

  assign valid_o = valid_q;
  assign q_o     = data_q;

endmodule

// File: rtl/pipe_stage_reg.sv
// Pipeline-boundary register with valid/ready handshake, optional skid entry,
// synchronous flush and a saturating bubble counter.
module pipe_stage_reg
  import pipe_pkg::*;
#(
  parameter int                DATA_W   = MEM_WB_DATA_BITS,
  parameter int                CTRL_W   = CTRL_BITS,
  parameter logic [CTRL_W-1:0] CTRL_RST = CTRL_W'(CTRL_NOP),
  parameter int                SKID     = 1,
  parameter int                CNT_W    = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  input  logic [CTRL_W-1:0] in_ctrl,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [CTRL_W-1:0] out_ctrl,
  output logic [CNT_W-1:0]  bubble_cnt
);

  localparam int               PW      = DATA_W + CTRL_W;
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic [PW-1:0]    in_pl_s, main_din_s, main_pl_s;
  logic             main_v_s, main_load_s, main_clear_s, accept_s;
  logic [CNT_W-1:0] bubble_q, bubble_d;

  assign in_pl_s  = {in_ctrl, in_data};
  assign accept_s = in_valid && in_ready;

  pipe_slot #(.W(PW)) u_main (
    .clk     (clk),
    .rst     (rst),
    .load_i  (main_load_s),
    .clear_i (main_clear_s),
    .d_i     (main_din_s),
    .valid_o (main_v_s),
    .q_o     (main_pl_s)
  );

  generate
    if (SKID != 0) begin : g_skid
      logic          skid_v_s, skid_load_s, skid_clear_s;
      logic [PW-1:0] skid_pl_s;

      assign in_ready = !skid_v_s;

      // Main refills from the skid entry before any new entry, keeping FIFO order.
      always_comb begin
        main_load_s  = 1'b0;
        main_clear_s = 1'b0;
        main_din_s   = in_pl_s;
        skid_load_s  = 1'b0;
        skid_clear_s = 1'b0;
        if (flush) begin
          main_clear_s = 1'b1;
          skid_clear_s = 1'b1;
        end else if (!main_v_s || out_ready) begin
          if (skid_v_s) begin
            main_load_s  = 1'b1;
            main_din_s   = skid_pl_s;
            skid_clear_s = 1'b1;
          end else if (accept_s) begin
            main_load_s  = 1'b1;
          end else begin
            main_clear_s = 1'b1;
          end
        end else if (accept_s) begin
          skid_load_s = 1'b1;
        end else begin
          skid_load_s = 1'b0;
        end
      end

      pipe_slot #(.W(PW)) u_skid (
        .clk     (clk),
        .rst     (rst),
        .load_i  (skid_load_s),
        .clear_i (skid_clear_s),
        .d_i     (in_pl_s),
        .valid_o (skid_v_s),
        .q_o     (skid_pl_s)
      );
    end else begin : g_single
      assign in_ready = !main_v_s || out_ready;

      always_comb begin
        main_load_s  = 1'b0;
        main_clear_s = 1'b0;
        main_din_s   = in_pl_s;
        if (flush) begin
          main_clear_s = 1'b1;
        end else if (accept_s) begin
          main_load_s  = 1'b1;
        end else if (main_v_s && out_ready) begin
          main_clear_s = 1'b1;
        end else begin
          main_clear_s = 1'b0;
        end
      end
    end
  endgenerate

  // An empty stage must never present live control to the next stage.
  always_comb begin
    out_valid = main_v_s;
    out_data  = main_pl_s[DATA_W-1:0];
    if (main_v_s) begin
      out_ctrl = main_pl_s[PW-1:DATA_W];
    end else begin
      out_ctrl = CTRL_RST;
    end
  end

  always_comb begin
    bubble_d = bubble_q;
    if (out_ready && !main_v_s && (bubble_q != CNT_MAX)) begin
      bubble_d = bubble_q + CNT_W'(1);
    end else begin
      bubble_d = bubble_q;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bubble_q <= '0;
    end else begin
      bubble_q <= bubble_d;
    end
  end

  assign bubble_cnt = bubble_q;

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Bench for pipe_stage_reg: a skid instance (CNT_W=4) and a single-register
// instance (CNT_W=16), both checked against a queue-based stage model.
module tb_pipe_stage_reg;

  localparam int DW = 32;
  localparam int CW = 4;
  localparam int EW = DW + CW;
  localparam int OW = 1 + 1 + CW + DW + 16;

  logic clk = 1'b0;
  logic rst;
  logic flush [2];
  logic iv [2];
  logic ir [2];
  logic ov [2];
  logic ordy [2];
  logic [DW-1:0] id [2];
  logic [DW-1:0] od [2];
  logic [CW-1:0] ic [2];
  logic [CW-1:0] oc [2];
  logic [3:0]  bc0;
  logic [15:0] bc1;

  int checks = 0;
  int errors = 0;

  // Model: the stage is a FIFO of capacity 2 (skid) or 1 (single register).
  logic [EW-1:0] mq0 [$];
  logic [EW-1:0] mq1 [$];
  logic [DW-1:0] m_last [2];
  int m_bub [2];
  int m_max [2];

  always #5 clk = ~clk;

  pipe_stage_reg #(.DATA_W(DW), .CTRL_W(CW), .CTRL_RST(4'h0), .SKID(1), .CNT_W(4)) dut_skid (
    .clk(clk), .rst(rst), .flush(flush[0]), .in_valid(iv[0]), .in_ready(ir[0]),
    .in_data(id[0]), .in_ctrl(ic[0]), .out_valid(ov[0]), .out_ready(ordy[0]),
    .out_data(od[0]), .out_ctrl(oc[0]), .bubble_cnt(bc0));

  pipe_stage_reg #(.DATA_W(DW), .CTRL_W(CW), .CTRL_RST(4'h0), .SKID(0), .CNT_W(16)) dut_single (
    .clk(clk), .rst(rst), .flush(flush[1]), .in_valid(iv[1]), .in_ready(ir[1]),
    .in_data(id[1]), .in_ctrl(ic[1]), .out_valid(ov[1]), .out_ready(ordy[1]),
    .out_data(od[1]), .out_ctrl(oc[1]), .bubble_cnt(bc1));

  function automatic int msize(int d);
    if (d == 0) return mq0.size();
    else return mq1.size();
  endfunction

  function automatic logic [EW-1:0] mhead(int d);
    if (d == 0) return mq0[0];
    else return mq1[0];
  endfunction

  function automatic logic m_ready(int d);
    if (d == 0) return msize(0) < 2;
    else return (msize(1) == 0) || ordy[1];
  endfunction

  function automatic logic [OW-1:0] expv(int d);
    logic [EW-1:0] h;
    logic [CW-1:0] c;
    logic [DW-1:0] dd;
    logic v;
    v  = msize(d) > 0;
    c  = '0;
    dd = m_last[d];
    if (v) begin
      h  = mhead(d);
      c  = h[EW-1:DW];
      dd = h[DW-1:0];
    end
    return {v, m_ready(d), c, dd, 16'(m_bub[d])};
  endfunction

  function automatic logic [OW-1:0] obsv(int d);
    if (d == 0) return {ov[0], ir[0], oc[0], od[0], 12'h000, bc0};
    else return {ov[1], ir[1], oc[1], od[1], bc1};
  endfunction

  task automatic m_reset();
    mq0.delete();
    mq1.delete();
    for (int d = 0; d < 2; d++) begin
      m_last[d] = '0;
      m_bub[d]  = 0;
    end
  endtask

  task automatic m_step(int d);
    int n;
    logic acc;
    logic [EW-1:0] e;
    logic [EW-1:0] h;
    n   = msize(d);
    acc = iv[d] && m_ready(d);
    e   = {ic[d], id[d]};
    if (ordy[d] && n == 0 && m_bub[d] < m_max[d]) m_bub[d]++;
    if (ordy[d] && n > 0) begin
      if (d == 0) void'(mq0.pop_front());
      else void'(mq1.pop_front());
    end
    if (flush[d]) begin
      if (d == 0) mq0.delete();
      else mq1.delete();
    end else if (acc) begin
      if (d == 0) mq0.push_back(e);
      else mq1.push_back(e);
    end
    if (msize(d) > 0) begin
      h = mhead(d);
      m_last[d] = h[DW-1:0];
    end
  endtask

  task automatic step();
    m_step(0);
    m_step(1);
    @(posedge clk);
    #1;
  endtask

  task automatic idle(int d);
    iv[d] = 1'b0; ordy[d] = 1'b0; flush[d] = 1'b0; id[d] = '0; ic[d] = '0;
  endtask

  task automatic test_reset();
    logic [OW-1:0] want;
    want = {1'b0, 1'b1, {CW{1'b0}}, {DW{1'b0}}, 16'h0000};
    for (int d = 0; d < 2; d++) begin
      iv[d] = 1'b1; ordy[d] = 1'b0; ic[d] = 4'h5;
    end
    for (int k = 0; k < 3; k++) begin
      id[0] = $urandom; id[1] = $urandom;
      step();
    end
    #2 rst = 1'b1;
    #1;
    for (int d = 0; d < 2; d++) begin
      checks++;
      if (obsv(d) !== want) begin
        errors++;
        $display("FAIL reset[%0d]: got %h want %h", d, obsv(d), want);
      end
    end
    m_reset();
    idle(0); idle(1);
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  task automatic test_stream();
    for (int k = 0; k <= 8; k++) begin
      iv[0] = (k < 8); id[0] = DW'(k + 1); ic[0] = 4'h3; ordy[0] = 1'b1;
      #1;
      checks++;
      if (obsv(0) !== expv(0)) begin
        errors++;
        $display("FAIL stream_model k=%0d: got %h want %h", k, obsv(0), expv(0));
      end
      if (k > 0) begin
        checks++;
        if (ov[0] !== 1'b1 || od[0] !== DW'(k) || bc0 !== 4'd1) begin
          errors++;
          $display("FAIL stream_data k=%0d: got v=%b d=%h b=%0d want v=1 d=%h b=1", k, ov[0], od[0], bc0, k);
        end
      end
      step();
    end
    idle(0);
  endtask

  task automatic test_backpressure();
    logic [DW-1:0] vals [3];
    logic [DW-1:0] got [$];
    int idx;
    vals[0] = 32'h0000_000A; vals[1] = 32'h0000_000B; vals[2] = 32'h0000_000C;
    idx = 0;
    for (int c = 0; c < 12; c++) begin
      iv[0] = (idx < 3); id[0] = (idx < 3) ? vals[idx] : '0; ic[0] = 4'h6;
      ordy[0] = (c == 0) || (c >= 5);
      #1;
      checks++;
      if (obsv(0) !== expv(0)) begin
        errors++;
        $display("FAIL bp_model c=%0d: got %h want %h", c, obsv(0), expv(0));
      end
      if (c == 2) begin
        checks++;
        if (ir[0] !== 1'b0) begin
          errors++;
          $display("FAIL bp_stall: got in_ready=%b want 0", ir[0]);
        end
      end
      if (ov[0] && ordy[0]) got.push_back(od[0]);
      if (iv[0] && m_ready(0)) idx++;
      step();
    end
    checks++;
    if (got.size() != 3 || got[0] !== vals[0] || got[1] !== vals[1] || got[2] !== vals[2]) begin
      errors++;
      $display("FAIL bp_order: got %0d entries first %h want A,B,C", got.size(), (got.size() > 0) ? got[0] : '0);
    end
    idle(0);
  endtask

  task automatic test_flush();
    logic [DW-1:0] seq [3];
    seq[0] = 32'h11; seq[1] = 32'h22; seq[2] = 32'h33;
    for (int c = 0; c < 3; c++) begin
      iv[0] = 1'b1; id[0] = seq[c]; ic[0] = 4'hF; ordy[0] = 1'b0; flush[0] = (c == 2);
      #1;
      checks++;
      if (obsv(0) !== expv(0)) begin
        errors++;
        $display("FAIL flush_fill c=%0d: got %h want %h", c, obsv(0), expv(0));
      end
      step();
    end
    idle(0);
    ordy[0] = 1'b1;
    #1;
    checks++;
    if (ov[0] !== 1'b0 || oc[0] !== 4'h0 || ir[0] !== 1'b1) begin
      errors++;
      $display("FAIL flush_kill: got v=%b c=%h r=%b want v=0 c=0 r=1", ov[0], oc[0], ir[0]);
    end
    for (int c = 0; c < 4; c++) begin
      checks++;
      if (obsv(0) !== expv(0) || (ov[0] && od[0] == 32'h33)) begin
        errors++;
        $display("FAIL flush_after c=%0d: got %h want %h", c, obsv(0), expv(0));
      end
      step();
    end
    idle(0);
  endtask

  task automatic test_saturation();
    rst = 1'b1;
    #2 rst = 1'b0;
    m_reset();
    ordy[0] = 1'b1;
    for (int c = 0; c < 20; c++) begin
      #1;
      checks++;
      if (obsv(0) !== expv(0)) begin
        errors++;
        $display("FAIL sat_model c=%0d: got %h want %h", c, obsv(0), expv(0));
      end
      step();
    end
    flush[0] = 1'b1;
    step();
    flush[0] = 1'b0;
    #1;
    checks++;
    if (bc0 !== 4'd15) begin
      errors++;
      $display("FAIL sat_hold: got %0d want 15", bc0);
    end
    idle(0);
  endtask

  task automatic test_noskid();
    logic [DW-1:0] got [$];
    int k;
    k = 1;
    for (int c = 0; c < 12; c++) begin
      iv[1] = (c < 10); id[1] = DW'(k); ic[1] = 4'h9; ordy[1] = (c >= 10) || (c % 2 == 0);
      #1;
      checks++;
      if (obsv(1) !== expv(1) || ir[1] !== (!ov[1] || ordy[1])) begin
        errors++;
        $display("FAIL noskid c=%0d: got %h want %h", c, obsv(1), expv(1));
      end
      if (ov[1] && ordy[1]) got.push_back(od[1]);
      if (iv[1] && m_ready(1)) k++;
      step();
    end
    checks++;
    if (got.size() != k - 1 || got.size() < 4) begin
      errors++;
      $display("FAIL noskid_count: got %0d want %0d", got.size(), k - 1);
    end
    for (int i = 0; i < got.size(); i++) begin
      checks++;
      if (got[i] !== DW'(i + 1)) begin
        errors++;
        $display("FAIL noskid_order[%0d]: got %h want %h", i, got[i], i + 1);
      end
    end
    idle(1);
  endtask

  task automatic test_random();
    for (int c = 0; c < 400; c++) begin
      for (int d = 0; d < 2; d++) begin
        iv[d]    = ($urandom_range(3) != 0);
        ordy[d]  = ($urandom_range(2) != 0);
        flush[d] = ($urandom_range(15) == 0);
        id[d]    = $urandom;
        ic[d]    = CW'($urandom_range(15));
      end
      #1;
      for (int d = 0; d < 2; d++) begin
        checks++;
        if (obsv(d) !== expv(d)) begin
          errors++;
          $display("FAIL random[%0d] c=%0d: got %h want %h", d, c, obsv(d), expv(d));
        end
      end
      step();
    end
    idle(0); idle(1);
  endtask

  initial begin
    m_max[0] = 15;
    m_max[1] = 65535;
    rst = 1'b1;
    idle(0); idle(1);
    m_reset();
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    test_reset();
    test_stream();
    test_backpressure();
    test_flush();
    test_saturation();
    test_noskid();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
